reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queued write entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 64, meaning the data width, matching the register file write port.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port alu_valid, input, 1 bit: the ALU result offer.
REQ-006 SHALL have port alu_ready, output, 1 bit: the ALU offer is accepted this cycle.
REQ-007 SHALL have ports alu_rd (input, 5 bits) and alu_data (input, XLEN bits): the ALU destination register and value.
REQ-008 SHALL have port mem_valid, input, 1 bit: the load-data offer.
REQ-009 SHALL have port mem_ready, output, 1 bit: the load offer is accepted this cycle.
REQ-010 SHALL have ports mem_rd (input, 5 bits) and mem_data (input, XLEN bits): the load destination register and value.
REQ-011 SHALL have port wb_stall, input, 1 bit: when high, the register-file write port is unavailable this cycle.
REQ-012 SHALL have port RegWrite, output, 1 bit: the register-file write enable.
REQ-013 SHALL have ports WriteReg (output, 5 bits) and WriteData (output, XLEN bits): the register-file write address and data.
REQ-014 SHALL have port pending, output, 32 bits: bit r high while any queued entry targets register r.
REQ-015 SHALL have port drop_cnt, output, 16 bits: the count of accepted writes to register x0.

Function
REQ-016 SHALL accept at most one producer per cycle; when both are valid, mem takes priority and alu_ready SHALL be 0.
REQ-017 SHALL set ready = (count < DEPTH) OR (pop this cycle), gated by the priority rule in REQ-016.
REQ-018 SHALL treat a handshake as valid AND ready on the same rising edge; the producer holds rd and data stable while valid is high and ready is low.
REQ-019 SHALL count an accepted write with rd = 0 in drop_cnt (saturating at 16'hFFFF), SHALL NOT enqueue it, and SHALL always assert ready for it regardless of FIFO fill level.
REQ-020 SHALL enqueue accepted writes with rd != 0 in FIFO order, and SHALL write them to the register file in acceptance order (WAW ordering preserved).
REQ-021 SHALL pop the head entry in any cycle where count > 0 and wb_stall = 0.
REQ-022 SHALL, for a popped entry, drive RegWrite = 1, WriteReg = rd and WriteData = data on the next cycle (registered outputs); otherwise RegWrite = 0 and WriteReg/WriteData hold their last values.
REQ-023 SHALL give a latency of exactly 1 cycle from acceptance into an empty FIFO with wb_stall = 0 to RegWrite high.
REQ-024 SHALL allow a push and a pop in the same cycle when full; count is unchanged and pointers wrap modulo DEPTH.
REQ-025 SHALL compute pending combinationally from the valid FIFO entries plus the registered in-flight entry (RegWrite high), so a register stays pending through its write cycle.
REQ-026 SHALL keep the FIFO at most DEPTH entries (full) and at least empty; no overflow or underflow occurs under any input sequence.

Reset
REQ-027 SHALL, while reset_n = 0, immediately clear count and the pointers, RegWrite, WriteReg, WriteData, pending and drop_cnt to 0; alu_ready and mem_ready SHALL be 0.
REQ-028 SHALL discard queued entries on reset mid-operation with no register-file write; operation resumes on the first clock edge after deassertion.

Structure
REQ-029 SHALL place XLEN_DEFAULT, REG_ADDR_W = 5, NUM_REGS = 32 and the wb_entry_t struct {rd, data} in the shared package wb_pkg.
REQ-030 SHALL implement the queue as the sub-module wb_fifo (parameters DEPTH and entry type, push/pop/full/empty/count, entry visibility for pending); arbitration, output registers and drop_cnt stay in reg_writeback.

Verification
REQ-031 SHALL cover: alu_valid with rd = 5, data = 64'h1234, FIFO empty -> RegWrite = 1, WriteReg = 5, WriteData = 64'h1234 one cycle later; pending[5] high for that cycle.
REQ-032 SHALL cover: alu and mem both valid (rd 3 and 4) -> mem accepted first; rd 4 written, then rd 3 on consecutive cycles.
REQ-033 SHALL cover: wb_stall = 1 with 5 offers of rd 1..5 -> 4 accepted, 5th sees ready = 0; release the stall -> writes rd 1,2,3,4,5 in order with no gaps.
REQ-034 SHALL cover: offers with rd = 0 while the FIFO is full -> ready = 1, drop_cnt increments each time, RegWrite never asserted for x0.
REQ-035 SHALL cover: reset_n low with 3 entries queued -> outputs and pending 0 immediately; no writes after release.
REQ-036 SHALL cover: two writes to rd 7 (values A then B) -> register file receives A then B; pending[7] clears only after B's write cycle.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// wb_pkg: shared constants and entry type for the register writeback path
package wb_pkg;
  localparam int XLEN_DEFAULT = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction
endpackage

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: producer offers, register-file write port and status of the writeback stage
interface reg_writeback_if #(
  parameter int XLEN = wb_pkg::XLEN_DEFAULT
);
  import wb_pkg::*;
  logic alu_valid;
  logic alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic mem_valid;
  logic mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;
  logic wb_stall;
  logic RegWrite;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic [XLEN-1:0] WriteData;
  logic [NUM_REGS-1:0] pending;
  logic [15:0] drop_cnt;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wb_stall,
    input alu_ready, mem_ready, RegWrite, WriteReg, WriteData, pending, drop_cnt
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wb_stall,
    output alu_ready, mem_ready, RegWrite, WriteReg, WriteData, pending, drop_cnt
  );
endinterface

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: circular queue of writeback entries; also reports which registers its live slots target
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  entry_t din,
  output entry_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [NUM_REGS-1:0] pend_mask
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push_ok, pop_ok;
  always_comb begin
    pop_ok = pop && count_q != '0;
    push_ok = push && (count_q != (AW+1)'(DEPTH) || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    pend_mask = '0;
    // a slot is live when its distance from the read pointer is below the fill level
    for (int i = 0; i < DEPTH; i++)
      pend_mask |= (AW'(AW'(i) - rd_ptr_q) < count_q) ? reg_bit(mem_q[i].rd) : '0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clock)
    if (push_ok) mem_q[wr_ptr_q] <= din;
  assign dout = mem_q[rd_ptr_q];
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU and load results into an ordered queue feeding the register-file write port
module reg_writeback import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic clock,
  input logic reset_n,
  reg_writeback_if.slave bus
);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } entry_t;
  localparam int CW = $clog2(DEPTH) + 1;
  entry_t in_e, head;
  logic full, empty, pop, push, bypass, space, mem_rdy, alu_rdy, accept, drop, take;
  logic [CW-1:0] count;
  logic [NUM_REGS-1:0] fifo_pend;
  logic reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  always_comb begin
    pop = !empty && !bus.wb_stall;
    space = !full || pop;
    mem_rdy = reset_n && (bus.mem_rd == '0 || space);
    alu_rdy = reset_n && !bus.mem_valid && (bus.alu_rd == '0 || space);
    in_e = bus.mem_valid ? entry_t'{bus.mem_rd, bus.mem_data} : entry_t'{bus.alu_rd, bus.alu_data};
    accept = (bus.mem_valid && mem_rdy) || (bus.alu_valid && alu_rdy);
    drop = accept && in_e.rd == '0;
    take = accept && in_e.rd != '0;
    // an entry arriving at an idle, unstalled queue goes straight to the write port
    bypass = take && count == '0 && !bus.wb_stall;
    push = take && !bypass;
    reg_write_d = pop || bypass;
    write_reg_d = pop ? head.rd : bypass ? in_e.rd : write_reg_q;
    write_data_d = pop ? head.data : bypass ? in_e.data : write_data_q;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end
  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din(in_e),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count),
    .pend_mask(fifo_pend)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      write_data_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      write_data_q <= write_data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  assign bus.mem_ready = mem_rdy;
  assign bus.alu_ready = alu_rdy;
  assign bus.RegWrite = reg_write_q;
  assign bus.WriteReg = write_reg_q;
  assign bus.WriteData = write_data_q;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.pending = fifo_pend | (reg_write_q ? reg_bit(write_reg_q) : '0);
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: table vectors, directed corner sequences and a randomized run against a queue model
module tb_reg_writeback;
  import wb_pkg::*;
  localparam int DEPTH = 4;
  localparam int XLEN = 64;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  reg_writeback_if #(.XLEN(XLEN)) bus();
  reg_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  wb_entry_t q[$];
  logic exp_we;
  logic [4:0] exp_wr;
  logic [63:0] exp_wd;
  logic [15:0] exp_drop;
  typedef struct {
    logic st, mv;
    logic [4:0] mrd;
    logic av;
    logic [4:0] ard;
    logic emr, ear, ewe;
    logic [4:0] ewr;
    logic [15:0] edrop;
  } vec_t;
  vec_t tbl [13];
  function automatic logic [63:0] mk(input logic [4:0] r);
    return {32'hCAFE_0000, 27'h0, r};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic st, input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                       input logic av, input logic [4:0] ard, input logic [63:0] ad);
    bus.wb_stall = st;
    bus.mem_valid = mv;
    bus.mem_rd = mrd;
    bus.mem_data = md;
    bus.alu_valid = av;
    bus.alu_rd = ard;
    bus.alu_data = ad;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    q.delete();
    exp_we = 0;
    exp_wr = 0;
    exp_wd = 0;
    exp_drop = 0;
  endtask
  function automatic logic [31:0] model_pend();
    logic [31:0] p;
    p = exp_we ? (32'd1 << exp_wr) : 32'd0;
    foreach (q[i]) p |= 32'd1 << q[i].rd;
    return p;
  endfunction
  task automatic step_out(input string tag, input logic we, input logic [4:0] wr, input logic [63:0] wd, input logic [31:0] pd);
    @(posedge clock);
    #1;
    chk({tag, ".RegWrite"}, bus.RegWrite, we);
    chk({tag, ".WriteReg"}, bus.WriteReg, wr);
    chk({tag, ".WriteData"}, bus.WriteData, wd);
    chk({tag, ".pending"}, bus.pending, pd);
  endtask
  logic hold_m = 0, hold_a = 0, mv, av, st, emr, ear;
  logic [4:0] mrd, ard;
  logic [63:0] md, ad;
  logic space;
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst.RegWrite", bus.RegWrite, 0);
    chk("rst.WriteReg", bus.WriteReg, 0);
    chk("rst.WriteData", bus.WriteData, 0);
    chk("rst.pending", bus.pending, 0);
    chk("rst.drop_cnt", bus.drop_cnt, 0);
    chk("rst.mem_ready", bus.mem_ready, 0);
    chk("rst.alu_ready", bus.alu_ready, 0);
    do_reset();
    // stall fills the queue, x0 drops while full, then the stall is released
    tbl[0] = '{1, 1, 5'd1, 0, 5'd0, 1, 0, 0, 5'd0, 16'd0};
    tbl[1] = '{1, 0, 5'd0, 1, 5'd2, 1, 1, 0, 5'd0, 16'd0};
    tbl[2] = '{1, 1, 5'd3, 1, 5'd9, 1, 0, 0, 5'd0, 16'd0};
    tbl[3] = '{1, 0, 5'd0, 1, 5'd4, 1, 1, 0, 5'd0, 16'd0};
    tbl[4] = '{1, 1, 5'd5, 0, 5'd0, 0, 0, 0, 5'd0, 16'd0};
    tbl[5] = '{1, 0, 5'd5, 1, 5'd0, 0, 1, 0, 5'd0, 16'd1};
    tbl[6] = '{1, 1, 5'd0, 1, 5'd6, 1, 0, 0, 5'd0, 16'd2};
    tbl[7] = '{0, 1, 5'd5, 0, 5'd0, 1, 0, 1, 5'd1, 16'd2};
    tbl[8] = '{0, 0, 5'd0, 0, 5'd0, 1, 1, 1, 5'd2, 16'd2};
    tbl[9] = '{0, 0, 5'd0, 0, 5'd0, 1, 1, 1, 5'd3, 16'd2};
    tbl[10] = '{0, 0, 5'd0, 0, 5'd0, 1, 1, 1, 5'd4, 16'd2};
    tbl[11] = '{0, 0, 5'd0, 0, 5'd0, 1, 1, 1, 5'd5, 16'd2};
    tbl[12] = '{0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 5'd5, 16'd2};
    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      drive(tbl[k].st, tbl[k].mv, tbl[k].mrd, mk(tbl[k].mrd), tbl[k].av, tbl[k].ard, mk(tbl[k].ard));
      #1;
      chk($sformatf("tbl%0d.mem_ready", k), bus.mem_ready, tbl[k].emr);
      chk($sformatf("tbl%0d.alu_ready", k), bus.alu_ready, tbl[k].ear);
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d.RegWrite", k), bus.RegWrite, tbl[k].ewe);
      chk($sformatf("tbl%0d.WriteReg", k), bus.WriteReg, tbl[k].ewr);
      if (tbl[k].ewr != 0) chk($sformatf("tbl%0d.WriteData", k), bus.WriteData, mk(tbl[k].ewr));
      chk($sformatf("tbl%0d.drop_cnt", k), bus.drop_cnt, tbl[k].edrop);
    end
    do_reset();
    @(negedge clock);
    drive(0, 0, 0, 0, 1, 5'd5, 64'h1234);
    #1 chk("single.alu_ready", bus.alu_ready, 1);
    step_out("single", 1, 5'd5, 64'h1234, 32'h20);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0);
    step_out("single_idle", 0, 5'd5, 64'h1234, 32'h0);
    @(negedge clock);
    drive(0, 1, 5'd4, mk(4), 1, 5'd3, mk(3));
    #1;
    chk("prio.mem_ready", bus.mem_ready, 1);
    chk("prio.alu_ready", bus.alu_ready, 0);
    step_out("prio1", 1, 5'd4, mk(4), 32'h10);
    @(negedge clock);
    drive(0, 0, 0, 0, 1, 5'd3, mk(3));
    step_out("prio2", 1, 5'd3, mk(3), 32'h08);
    @(negedge clock);
    drive(0, 0, 0, 0, 1, 5'd7, 64'hAAAA);
    step_out("waw.A", 1, 5'd7, 64'hAAAA, 32'h80);
    @(negedge clock);
    drive(0, 0, 0, 0, 1, 5'd7, 64'hBBBB);
    step_out("waw.B", 1, 5'd7, 64'hBBBB, 32'h80);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0);
    step_out("waw.done", 0, 5'd7, 64'hBBBB, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      drive(1, 0, 0, 0, 1, 5'(k), mk(5'(k)));
    end
    @(negedge clock);
    drive(1, 0, 0, 0, 0, 0, 0);
    #1 chk("rstq.pending_before", bus.pending, 32'h0E);
    reset_n = 1'b0;
    #1;
    chk("rstq.RegWrite", bus.RegWrite, 0);
    chk("rstq.WriteReg", bus.WriteReg, 0);
    chk("rstq.WriteData", bus.WriteData, 0);
    chk("rstq.pending", bus.pending, 0);
    chk("rstq.mem_ready", bus.mem_ready, 0);
    chk("rstq.alu_ready", bus.alu_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      chk("rstq.no_write", bus.RegWrite, 0);
      chk("rstq.no_pending", bus.pending, 0);
    end
    do_reset();
    hold_m = 0;
    hold_a = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (!hold_m) begin
        mv = $urandom_range(0, 1) == 1;
        mrd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        md = {$urandom, $urandom};
      end
      if (!hold_a) begin
        av = $urandom_range(0, 1) == 1;
        ard = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        ad = {$urandom, $urandom};
      end
      st = $urandom_range(0, 2) == 0;
      drive(st, mv, mrd, md, av, ard, ad);
      #1;
      space = q.size() < DEPTH || (q.size() > 0 && !st);
      emr = mrd == 0 || space;
      ear = !mv && (ard == 0 || space);
      chk("rnd.mem_ready", bus.mem_ready, emr);
      chk("rnd.alu_ready", bus.alu_ready, ear);
      hold_m = mv && !emr;
      hold_a = av && !ear;
      if (mv && emr) begin
        if (mrd == 0) exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 1;
        else q.push_back('{mrd, md});
      end else if (av && ear) begin
        if (ard == 0) exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 1;
        else q.push_back('{ard, ad});
      end
      if (!st && q.size() > 0) begin
        wb_entry_t e;
        e = q.pop_front();
        exp_we = 1;
        exp_wr = e.rd;
        exp_wd = e.data;
      end else exp_we = 0;
      step_out("rnd", exp_we, exp_wr, exp_wd, model_pend());
      chk("rnd.drop_cnt", bus.drop_cnt, exp_drop);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
